rf215_rx_link_ctrl: RTL

Link supervisor and sequencer for the AT86RF215 LVDS RX deserialiser on the delayedCLK domain.
- Holds the deserialiser in reset until the PLL is locked and software enables RX.
- Qualifies incoming 32-bit words, declares link up/down with hysteresis, and forces a timed re-sync (receiver reset pulse) on persistent errors or timeouts.
- Splits qualified words into 14-bit I/Q samples for the downstream DSP chain.

---
 rtl/rf215_rx_pkg.sv | 40 ++++
 rtl/rf215_word_classify.sv | 21 ++
 rtl/rf215_rx_link_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf215_rx_pkg.sv
// Shared types and constants for the AT86RF215 LVDS RX link controller.
// Word layout: [31:30] I sync, [29:16] I sample, [15:14] Q sync, [13:0] Q sample.
package rf215_rx_pkg;

  // Link supervisor states; the numeric values are visible on state_o
  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_HUNT   = 3'd1,
    ST_LOCKED = 3'd2,
    ST_RESYNC = 3'd3
  } rx_state_e;

  // Classification of a deserialiser word
  typedef enum logic [1:0] {
    CLS_GOOD = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_BAD  = 2'd2
  } word_class_e;

  localparam int WORD_W   = 32;
  localparam int SAMPLE_W = 14;

  localparam logic [1:0] I_SYNC = 2'b10;
  localparam logic [1:0] Q_SYNC = 2'b01;

  localparam int I_SYNC_MSB = 31;
  localparam int I_SYNC_LSB = 30;
  localparam int I_MSB      = 29;
  localparam int I_LSB      = 16;
  localparam int Q_SYNC_MSB = 15;
  localparam int Q_SYNC_LSB = 14;
  localparam int Q_MSB      = 13;
  localparam int Q_LSB      = 0;

  // Saturating 32-bit increment used by the optional statistics counters
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    sat_inc32 = (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/rf215_word_classify.sv
// Combinational classifier for a 32-bit RF215 LVDS word.
// An all-zero word is reported separately so callers can treat idle fill as neutral.
module rf215_word_classify
  import rf215_rx_pkg::*;
(
  input  logic [31:0] rx_word,
  output logic [1:0]  word_class
);

  // Zero takes precedence; otherwise both sync fields must match to be good
  always_comb begin
    word_class = CLS_BAD;
    if (rx_word == 32'd0) begin
      word_class = CLS_ZERO;
    end else if ((rx_word[I_SYNC_MSB:I_SYNC_LSB] == I_SYNC) &&
                 (rx_word[Q_SYNC_MSB:Q_SYNC_LSB] == Q_SYNC)) begin
      word_class = CLS_GOOD;
    end
  end

endmodule

// File: rtl/rf215_rx_link_ctrl.sv
// Link supervisor and sequencer for the AT86RF215 LVDS RX deserialiser.
// Holds the deserialiser in reset until enabled, hunts for sync, declares link
// up/down with hysteresis, forces timed re-syncs and emits 14-bit I/Q samples.
// Optional statistics counters are built when RF215_RX_STATS_EN is defined.
module rf215_rx_link_ctrl
  import rf215_rx_pkg::*;
#(
  parameter int GOOD_TO_LOCK = 4,
  parameter int BAD_TO_DROP  = 3,
  parameter int HUNT_TIMEOUT = 4096,
  parameter int WD_CYCLES    = 48,
  parameter int RST_PULSE    = 8
) (
  input  logic        delayedCLK,
  input  logic        rst_n,
  input  logic        rx_enable,
  input  logic        pll_locked,
  input  logic        word_valid,
  input  logic [31:0] rx_word,
  output logic        rx_rst_n,
  output logic [13:0] i_sample,
  output logic [13:0] q_sample,
  output logic        sample_valid,
  output logic        link_up,
  output logic [2:0]  state_o,
  output logic [15:0] resync_cnt
`ifdef RF215_RX_STATS_EN
  ,
  output logic [31:0] good_cnt,
  output logic [31:0] bad_cnt,
  output logic [31:0] zero_cnt
`endif
);

  localparam int RUN_MAX = (GOOD_TO_LOCK > BAD_TO_DROP) ? GOOD_TO_LOCK : BAD_TO_DROP;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam int TMR_W   = $clog2(HUNT_TIMEOUT + 1);
  localparam int WD_W    = $clog2(WD_CYCLES + 1);
  localparam int PULSE_W = $clog2(RST_PULSE + 1);

  // Last count value before each threshold is reached
  localparam logic [RUN_W-1:0]   GOOD_LAST  = RUN_W'(GOOD_TO_LOCK - 1);
  localparam logic [RUN_W-1:0]   BAD_LAST   = RUN_W'(BAD_TO_DROP - 1);
  localparam logic [TMR_W-1:0]   HUNT_LAST  = TMR_W'(HUNT_TIMEOUT - 1);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(WD_CYCLES - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE - 1);

  rx_state_e            state_q, state_d;
  logic [RUN_W-1:0]     good_run_q, good_run_d;
  logic [RUN_W-1:0]     bad_run_q, bad_run_d;
  logic [TMR_W-1:0]     hunt_tmr_q, hunt_tmr_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [PULSE_W-1:0]   pulse_q, pulse_d;
  logic [15:0]          resync_cnt_q, resync_cnt_d;
  logic                 rx_rst_n_q, rx_rst_n_d;
  logic                 link_up_q, link_up_d;
  logic                 sample_valid_q, sample_valid_d;
  logic [SAMPLE_W-1:0]  i_sample_q, i_sample_d;
  logic [SAMPLE_W-1:0]  q_sample_q, q_sample_d;

  logic [1:0]  word_class_raw;
  word_class_e word_class;
  logic        link_ok;
  logic        is_good;
  logic        is_bad;
  logic        is_zero;
  logic        wd_expire;
  logic        bad_event;

  rf215_word_classify u_classify (
    .rx_word    (rx_word),
    .word_class (word_class_raw)
  );

  // Qualify the word class with the strobe and combine the enable conditions
  always_comb begin
    word_class = word_class_e'(word_class_raw);
    link_ok    = rx_enable && pll_locked;
    is_good    = word_valid && (word_class == CLS_GOOD);
    is_bad     = word_valid && (word_class == CLS_BAD);
    is_zero    = word_valid && (word_class == CLS_ZERO);
  end

  // Next-state, run counters, timers and sample capture
  always_comb begin
    state_d        = state_q;
    good_run_d     = good_run_q;
    bad_run_d      = bad_run_q;
    hunt_tmr_d     = hunt_tmr_q;
    wd_d           = wd_q;
    pulse_d        = pulse_q;
    resync_cnt_d   = resync_cnt_q;
    sample_valid_d = 1'b0;
    i_sample_d     = i_sample_q;
    q_sample_d     = q_sample_q;
    wd_expire      = 1'b0;
    bad_event      = 1'b0;

    if ((state_q == ST_LOCKED) && is_good) begin
      sample_valid_d = 1'b1;
      i_sample_d     = rx_word[I_MSB:I_LSB];
      q_sample_d     = rx_word[Q_MSB:Q_LSB];
    end

    if (!link_ok) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_HUNT;
        end

        ST_HUNT: begin
          hunt_tmr_d = hunt_tmr_q + TMR_W'(1);
          if (is_good) begin
            good_run_d = good_run_q + RUN_W'(1);
          end else if (is_bad) begin
            good_run_d = '0;
          end
          if (is_good && (good_run_q == GOOD_LAST)) begin
            state_d = ST_LOCKED;
          end else if (hunt_tmr_q == HUNT_LAST) begin
            state_d = ST_RESYNC;
          end
        end

        ST_LOCKED: begin
          wd_expire = !word_valid && (wd_q == WD_LAST);
          bad_event = is_bad || wd_expire;
          wd_d      = (word_valid || wd_expire) ? '0 : wd_q + WD_W'(1);
          if (is_good) begin
            bad_run_d = '0;
          end else if (bad_event) begin
            bad_run_d = bad_run_q + RUN_W'(1);
            if (bad_run_q == BAD_LAST) begin
              state_d = ST_RESYNC;
            end
          end
        end

        ST_RESYNC: begin
          pulse_d = pulse_q + PULSE_W'(1);
          if (pulse_q == PULSE_LAST) begin
            state_d = ST_HUNT;
          end
        end

        default: begin
          state_d = ST_OFF;
        end
      endcase
    end

    if (state_d != state_q) begin
      case (state_d)
        ST_OFF: begin
          good_run_d = '0;
          bad_run_d  = '0;
          hunt_tmr_d = '0;
          wd_d       = '0;
          pulse_d    = '0;
        end
        ST_HUNT: begin
          good_run_d = '0;
          bad_run_d  = '0;
          hunt_tmr_d = '0;
        end
        ST_LOCKED: begin
          good_run_d = '0;
          bad_run_d  = '0;
          wd_d       = '0;
        end
        ST_RESYNC: begin
          pulse_d = '0;
          if (resync_cnt_q != 16'hFFFF) begin
            resync_cnt_d = resync_cnt_q + 16'd1;
          end
        end
        default: begin
          good_run_d = '0;
        end
      endcase
    end

    rx_rst_n_d = (state_d == ST_HUNT) || (state_d == ST_LOCKED);
    link_up_d  = (state_d == ST_LOCKED);
  end

  // State and datapath registers
  always_ff @(posedge delayedCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_OFF;
      good_run_q     <= '0;
      bad_run_q      <= '0;
      hunt_tmr_q     <= '0;
      wd_q           <= '0;
      pulse_q        <= '0;
      resync_cnt_q   <= '0;
      rx_rst_n_q     <= 1'b0;
      link_up_q      <= 1'b0;
      sample_valid_q <= 1'b0;
      i_sample_q     <= '0;
      q_sample_q     <= '0;
    end else begin
      state_q        <= state_d;
      good_run_q     <= good_run_d;
      bad_run_q      <= bad_run_d;
      hunt_tmr_q     <= hunt_tmr_d;
      wd_q           <= wd_d;
      pulse_q        <= pulse_d;
      resync_cnt_q   <= resync_cnt_d;
      rx_rst_n_q     <= rx_rst_n_d;
      link_up_q      <= link_up_d;
      sample_valid_q <= sample_valid_d;
      i_sample_q     <= i_sample_d;
      q_sample_q     <= q_sample_d;
    end
  end

  assign rx_rst_n     = rx_rst_n_q;
  assign link_up      = link_up_q;
  assign sample_valid = sample_valid_q;
  assign i_sample     = i_sample_q;
  assign q_sample     = q_sample_q;
  assign state_o      = state_q;
  assign resync_cnt   = resync_cnt_q;

`ifdef RF215_RX_STATS_EN
  logic [31:0] good_cnt_q, good_cnt_d;
  logic [31:0] bad_cnt_q, bad_cnt_d;
  logic [31:0] zero_cnt_q, zero_cnt_d;

  // Count each word class outside OFF; heading into OFF wipes the statistics
  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    zero_cnt_d = zero_cnt_q;
    if (state_d == ST_OFF) begin
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      zero_cnt_d = '0;
    end else if (state_q != ST_OFF) begin
      if (is_good) good_cnt_d = sat_inc32(good_cnt_q);
      if (is_bad)  bad_cnt_d  = sat_inc32(bad_cnt_q);
      if (is_zero) zero_cnt_d = sat_inc32(zero_cnt_q);
    end
  end

  // Statistics registers
  always_ff @(posedge delayedCLK or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      zero_cnt_q <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign good_cnt = good_cnt_q;
  assign bad_cnt  = bad_cnt_q;
  assign zero_cnt = zero_cnt_q;
`else
  // Zero words only matter to the statistics counters
  logic unused_zero;
  assign unused_zero = is_zero;
`endif

endmodule
